// File: rtl/cg_vector_pingpong_mem_if.sv
// Block transfer bundle between the CG datapath and a ping-pong vector store.
// master = datapath side, slave = memory side.
interface cg_vector_pingpong_mem_if #(
    parameter int NO_OF_UNITS   = 8,
    parameter int ELEMENT_WIDTH = 32
);
    localparam int BW = ELEMENT_WIDTH * NO_OF_UNITS;

    logic          wr_en;
    logic [BW-1:0] wr_data;
    logic          rd_req;
    logic          swap;
    logic [BW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic          wr_done;
    logic          bank_sel;
    logic          err;

    modport master (
        output wr_en, wr_data, rd_req, swap,
        input  rd_data, rd_valid, rd_last, wr_done, bank_sel, err
    );

    modport slave (
        input  wr_en, wr_data, rd_req, swap,
        output rd_data, rd_valid, rd_last, wr_done, bank_sel, err
    );
endinterface

// File: rtl/cg_vector_pingpong_mem.sv
// Double-buffered CG vector store: reads come from bank_sel, writes go to !bank_sel.
// Optional CG_MEM_ZERO_PAD_EN stores lanes beyond NUM_EQN as zero.
module cg_vector_pingpong_mem #(
    parameter int NUM_EQN       = 10,
    parameter int NO_OF_UNITS   = 8,
    parameter int ELEMENT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    cg_vector_pingpong_mem_if.slave  bus
);
    localparam int DEPTH = (NUM_EQN + NO_OF_UNITS - 1) / NO_OF_UNITS;
    localparam int BW    = ELEMENT_WIDTH * NO_OF_UNITS;
    localparam int WP_W  = $clog2(DEPTH + 1);
    localparam int RP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WP_W-1:0] WP_LAST = WP_W'(DEPTH - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(DEPTH - 1);

    logic [BW-1:0]   mem [2][DEPTH];

    logic [RP_W-1:0] rd_ptr;
    logic [WP_W-1:0] wr_ptr;
    logic [BW-1:0]   rd_data_q;
    logic            rd_valid_q;
    logic            rd_last_q;
    logic            wr_done_q;
    logic            bank_sel_q;
    logic            err_q;

    logic            swap_ok;
    logic            wr_ok;
    logic            err_evt;
    logic [RP_W-1:0] wr_idx;
    logic [BW-1:0]   wr_block;

    // A swap is judged on the pre-edge wr_done; an accepted swap implies wr_done,
    // so any write in the same cycle is already dropped (and flagged) by wr_ok.
    assign swap_ok = bus.swap && wr_done_q;
    assign wr_ok   = bus.wr_en && !wr_done_q;
    assign err_evt = (bus.wr_en && wr_done_q) || (bus.swap && !wr_done_q);
    assign wr_idx  = wr_ptr[RP_W-1:0];

    always_comb begin
        wr_block = bus.wr_data;
`ifdef CG_MEM_ZERO_PAD_EN
        for (int l = 0; l < NO_OF_UNITS; l++) begin
            if ((int'(wr_ptr) * NO_OF_UNITS + l) >= NUM_EQN)
                wr_block[l*ELEMENT_WIDTH +: ELEMENT_WIDTH] = '0;
        end
`endif
    end

    // Storage has no reset; a reset cycle only suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok)
            mem[~bank_sel_q][wr_idx] <= wr_block;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            wr_done_q  <= 1'b0;
            bank_sel_q <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            rd_valid_q <= bus.rd_req;
            rd_last_q  <= bus.rd_req && (rd_ptr == RP_LAST);
            if (bus.rd_req) begin
                rd_data_q <= mem[bank_sel_q][rd_ptr];
                rd_ptr    <= (rd_ptr == RP_LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_ptr == WP_LAST)
                    wr_done_q <= 1'b1;
            end
            if (err_evt)
                err_q <= 1'b1;
            // Placed last so pointer resets win over the read/write increments.
            if (swap_ok) begin
                bank_sel_q <= ~bank_sel_q;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                wr_done_q  <= 1'b0;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_last_q;
    assign bus.wr_done  = wr_done_q;
    assign bus.bank_sel = bank_sel_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_cg_vector_pingpong_mem.sv
// Directed bench for cg_vector_pingpong_mem (NUM_EQN=10, 8 lanes, DEPTH=2).
// Honours CG_MEM_ZERO_PAD_EN for the padding expectations.
module tb_cg_vector_pingpong_mem;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cg_vector_pingpong_mem_if #(.NO_OF_UNITS(8), .ELEMENT_WIDTH(32)) bus ();

    cg_vector_pingpong_mem #(.NUM_EQN(10), .NO_OF_UNITS(8), .ELEMENT_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [255:0] mk(input logic [31:0] base);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = base + i;
        return r;
    endfunction

    logic [255:0] blk_a, blk_b, blk_c, blk_d, blk_e, blk_f, blk_g, blk_h, blk_p, ones, pad_exp;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = 1'b0; bus.rd_req = 1'b0; bus.swap = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); bus.wr_data = '0;
        step(); step();
        reset = 1'b0;
        checks++; if (bus.rd_data !== 256'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", bus.rd_data); end
        checks++; if ({bus.rd_valid, bus.rd_last, bus.wr_done, bus.bank_sel, bus.err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {bus.rd_valid, bus.rd_last, bus.wr_done, bus.bank_sel, bus.err}); end
    endtask

    task automatic test_load();
        bus.wr_en = 1'b1; bus.wr_data = blk_a; step();
        checks++; if (bus.wr_done !== 1'b0) begin errors++; $display("FAIL load_wr_done_early got %b exp 0", bus.wr_done); end
        bus.wr_data = blk_b; step(); bus.wr_en = 1'b0;
        checks++; if (bus.wr_done !== 1'b1) begin errors++; $display("FAIL load_wr_done got %b exp 1", bus.wr_done); end
        bus.swap = 1'b1; step(); bus.swap = 1'b0;
        checks++; if ({bus.bank_sel, bus.wr_done, bus.err} !== 3'b100) begin
            errors++; $display("FAIL load_swap got bank/done/err %b exp 100", {bus.bank_sel, bus.wr_done, bus.err}); end
        bus.rd_req = 1'b1; step();
        checks++; if ({bus.rd_valid, bus.rd_last} !== 2'b10 || bus.rd_data !== blk_a) begin
            errors++; $display("FAIL load_rd0 got %b %h exp 10 %h", {bus.rd_valid, bus.rd_last}, bus.rd_data, blk_a); end
        step(); bus.rd_req = 1'b0;
        checks++; if ({bus.rd_valid, bus.rd_last} !== 2'b11 || bus.rd_data !== blk_b) begin
            errors++; $display("FAIL load_rd1 got %b %h exp 11 %h", {bus.rd_valid, bus.rd_last}, bus.rd_data, blk_b); end
        step();
        checks++; if ({bus.rd_valid, bus.rd_last} !== 2'b00 || bus.rd_data !== blk_b) begin
            errors++; $display("FAIL load_hold got %b %h exp 00 %h", {bus.rd_valid, bus.rd_last}, bus.rd_data, blk_b); end
    endtask

    task automatic test_wrap();
        logic [255:0] exp_d [5];
        logic         exp_l [5];
        exp_d = '{blk_a, blk_b, blk_a, blk_b, blk_a};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bus.rd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_last !== exp_l[i] || bus.rd_data !== exp_d[i]) begin
                errors++; $display("FAIL wrap_%0d got v=%b l=%b %h exp v=1 l=%b %h", i, bus.rd_valid, bus.rd_last, bus.rd_data, exp_l[i], exp_d[i]); end
        end
        bus.rd_req = 1'b0; step();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL wrap_err got %b exp 0", bus.err); end
    endtask

    // Read pointer sits at 1 after the odd-length wrap stream.
    task automatic test_pingpong();
        bus.rd_req = 1'b1; bus.wr_en = 1'b1; bus.wr_data = blk_c; step();
        checks++; if (bus.rd_data !== blk_b || bus.rd_last !== 1'b1) begin
            errors++; $display("FAIL pp_rd_b got %h l=%b exp %h l=1", bus.rd_data, bus.rd_last, blk_b); end
        bus.wr_data = blk_d; step(); bus.wr_en = 1'b0;
        checks++; if (bus.rd_data !== blk_a || bus.wr_done !== 1'b1) begin
            errors++; $display("FAIL pp_rd_a got %h done=%b exp %h done=1", bus.rd_data, bus.wr_done, blk_a); end
        bus.swap = 1'b1; step(); bus.swap = 1'b0;
        checks++; if (bus.rd_data !== blk_b || bus.rd_last !== 1'b1 || bus.bank_sel !== 1'b0) begin
            errors++; $display("FAIL pp_swap_rd got %h l=%b bank=%b exp %h l=1 bank=0", bus.rd_data, bus.rd_last, bus.bank_sel, blk_b); end
        step();
        checks++; if (bus.rd_data !== blk_c || bus.rd_last !== 1'b0) begin
            errors++; $display("FAIL pp_rd_c got %h l=%b exp %h l=0", bus.rd_data, bus.rd_last, blk_c); end
        step(); bus.rd_req = 1'b0;
        checks++; if (bus.rd_data !== blk_d || bus.rd_last !== 1'b1 || bus.err !== 1'b0) begin
            errors++; $display("FAIL pp_rd_d got %h l=%b err=%b exp %h l=1 err=0", bus.rd_data, bus.rd_last, bus.err, blk_d); end
        step();
    endtask

    task automatic test_errors();
        bus.wr_en = 1'b1; bus.wr_data = blk_e; step(); bus.wr_en = 1'b0;
        bus.swap = 1'b1; step(); bus.swap = 1'b0;
        checks++; if ({bus.err, bus.bank_sel, bus.wr_done} !== 3'b100) begin
            errors++; $display("FAIL err_swap_reject got err/bank/done %b exp 100", {bus.err, bus.bank_sel, bus.wr_done}); end
        bus.wr_en = 1'b1; bus.wr_data = blk_f; step();
        checks++; if (bus.wr_done !== 1'b1) begin errors++; $display("FAIL err_wr_done got %b exp 1", bus.wr_done); end
        bus.wr_data = blk_g; step();
        checks++; if (bus.err !== 1'b1 || bus.wr_done !== 1'b1) begin
            errors++; $display("FAIL err_overflow got err=%b done=%b exp 1 1", bus.err, bus.wr_done); end
        bus.wr_data = blk_h; bus.swap = 1'b1; step(); idle();
        checks++; if (bus.bank_sel !== 1'b1 || bus.wr_done !== 1'b0) begin
            errors++; $display("FAIL err_swap_wr got bank=%b done=%b exp 1 0", bus.bank_sel, bus.wr_done); end
        bus.rd_req = 1'b1; step();
        checks++; if (bus.rd_data !== blk_e) begin errors++; $display("FAIL err_rd_e got %h exp %h", bus.rd_data, blk_e); end
        step(); bus.rd_req = 1'b0;
        checks++; if (bus.rd_data !== blk_f) begin errors++; $display("FAIL err_rd_f got %h exp %h", bus.rd_data, blk_f); end
    endtask

    // Rejected swap alongside a write: the write must still land.
    task automatic test_pad();
        bus.wr_en = 1'b1; bus.wr_data = blk_p; bus.swap = 1'b1; step(); bus.swap = 1'b0;
        checks++; if (bus.bank_sel !== 1'b1 || bus.wr_done !== 1'b0) begin
            errors++; $display("FAIL pad_swap_reject got bank=%b done=%b exp 1 0", bus.bank_sel, bus.wr_done); end
        bus.wr_data = ones; step(); bus.wr_en = 1'b0;
        checks++; if (bus.wr_done !== 1'b1) begin errors++; $display("FAIL pad_wr_done got %b exp 1", bus.wr_done); end
        bus.swap = 1'b1; step(); bus.swap = 1'b0;
        bus.rd_req = 1'b1; step();
        checks++; if (bus.rd_data !== blk_p) begin errors++; $display("FAIL pad_blk0 got %h exp %h", bus.rd_data, blk_p); end
        step(); bus.rd_req = 1'b0;
        checks++; if (bus.rd_data !== pad_exp || bus.rd_last !== 1'b1) begin
            errors++; $display("FAIL pad_blk1 got %h l=%b exp %h l=1", bus.rd_data, bus.rd_last, pad_exp); end
    endtask

    task automatic test_reset_abort();
        bus.rd_req = 1'b1; reset = 1'b1; step();
        reset = 1'b0; bus.rd_req = 1'b0; step();
        checks++; if ({bus.rd_valid, bus.bank_sel, bus.err, bus.wr_done} !== 4'b0) begin
            errors++; $display("FAIL abort_flags got %b exp 0000", {bus.rd_valid, bus.bank_sel, bus.err, bus.wr_done}); end
        bus.rd_req = 1'b1; step(); bus.rd_req = 1'b0;
        checks++; if (bus.rd_data !== blk_p || bus.rd_valid !== 1'b1) begin
            errors++; $display("FAIL abort_mem_kept got %h v=%b exp %h v=1", bus.rd_data, bus.rd_valid, blk_p); end
    endtask

    initial begin
        blk_a = mk(32'hA000_0000); blk_b = mk(32'hB000_0000);
        blk_c = mk(32'hC000_0000); blk_d = mk(32'hD000_0000);
        blk_e = mk(32'hE000_0000); blk_f = mk(32'hF000_0000);
        blk_g = mk(32'h1200_0000); blk_h = mk(32'h3400_0000);
        blk_p = mk(32'h5600_0000);
        ones  = {8{32'h3F80_0000}};
`ifdef CG_MEM_ZERO_PAD_EN
        pad_exp = {192'h0, 32'h3F80_0000, 32'h3F80_0000};
`else
        pad_exp = ones;
`endif
        idle(); bus.wr_data = '0;
        test_reset();
        test_load();
        test_wrap();
        test_pingpong();
        test_errors();
        test_pad();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
